// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state encoding and derived-size helpers for the FC output buffer
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SEND  = 2'd2
    } obuf_state_t;

    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    function automatic int obuf_data_size(input int data_size, input int xbar_size);
        return (data_size == 1) ? $clog2(xbar_size) : 2 * data_size + $clog2(xbar_size);
    endfunction

    function automatic int num_channels(input int bus_width, input int odata_size);
        return bus_width / odata_size;
    endfunction

    function automatic int fifo_length(input int data_size, input int xbar_size, input int nch);
        return ((xbar_size / data_size) + nch - 1) / nch;
    endfunction

endpackage

// File: rtl/fc_obuf_quant.sv
// rtl/fc_obuf_quant.sv - shift and narrow one accumulator to an activation
// FC_OBUF_RELU_EN selects saturating ReLU clamping instead of plain truncation.
module fc_obuf_quant #(
    parameter int DATA_SIZE      = 8,
    parameter int OBUF_DATA_SIZE = 23,
    parameter int OUT_SHIFT      = 7
) (
    input  logic [OBUF_DATA_SIZE-1:0] i_acc,
    output logic [DATA_SIZE-1:0]      o_q
);

`ifdef FC_OBUF_RELU_EN
    localparam logic signed [OBUF_DATA_SIZE-1:0] QMAX = OBUF_DATA_SIZE'((1 << DATA_SIZE) - 1);

    logic signed [OBUF_DATA_SIZE-1:0] shifted;

    assign shifted = $signed(i_acc) >>> OUT_SHIFT;

    always_comb begin
        o_q = shifted[DATA_SIZE-1:0];
        if (shifted < 0) begin
            o_q = '0;
        end else if (shifted > QMAX) begin
            o_q = '1;
        end
    end
`else
    assign o_q = DATA_SIZE'($signed(i_acc) >>> OUT_SHIFT);
`endif

endmodule

// File: rtl/fc_obuf.sv
// rtl/fc_obuf.sv - FC-layer output buffer: shift-add accumulate, quantise, stream rows to next ibuf
// Quantiser behaviour is selected by FC_OBUF_RELU_EN (see fc_obuf_quant).
module fc_obuf
    import fc_pkg::*;
#(
    parameter  int DATA_SIZE      = 8,
    parameter  int XBAR_SIZE      = 128,
    parameter  int OBUF_BUS_WIDTH = 46,
    parameter  int H_CIM_TILES    = 1,
    parameter  int OUT_SHIFT      = 7,
    localparam int ODS            = obuf_data_size(DATA_SIZE, XBAR_SIZE),
    localparam int NCH            = num_channels(OBUF_BUS_WIDTH, ODS),
    localparam int FL             = fifo_length(DATA_SIZE, XBAR_SIZE, NCH),
    localparam int NE             = H_CIM_TILES * NCH,
    localparam int AW             = clog2_min1(FL),
    localparam int BW             = clog2_min1(DATA_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic                              i_valid,
    input  logic [AW-1:0]                     i_addr,
    input  logic [BW-1:0]                     i_bit,
    input  logic                              i_last,
    input  logic [H_CIM_TILES*OBUF_BUS_WIDTH-1:0] i_data,
    input  logic                              i_ready,
    output logic                              o_we,
    output logic [NE*DATA_SIZE-1:0]           o_data,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam logic [AW-1:0] CNT_LAST = AW'(FL - 1);

    obuf_state_t              state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic                     turn_q, turn_d;
    logic                     we_q, we_d;
    logic                     done_q, done_d;
    logic [NE*DATA_SIZE-1:0]  data_q, data_d;
    logic [ODS-1:0]           acc_q [FL][NE];
    logic [ODS-1:0]           acc_d [FL][NE];
    logic [ODS-1:0]           partial [NE];
    logic [NE*DATA_SIZE-1:0]  quant_row;
    logic                     beat_ok;

    for (genvar e = 0; e < NE; e++) begin : g_elem
        assign partial[e] = i_data[(e / NCH) * OBUF_BUS_WIDTH + (e % NCH) * ODS +: ODS];

        fc_obuf_quant #(
            .DATA_SIZE      (DATA_SIZE),
            .OBUF_DATA_SIZE (ODS),
            .OUT_SHIFT      (OUT_SHIFT)
        ) u_quant (
            .i_acc (acc_q[cnt_q][e]),
            .o_q   (quant_row[e*DATA_SIZE +: DATA_SIZE])
        );
    end

    assign beat_ok = (32'(i_bit) < DATA_SIZE) && (32'(i_addr) < FL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        turn_d  = turn_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        data_d  = data_q;

        if (i_start) begin
            for (int f = 0; f < FL; f++) begin
                for (int e = 0; e < NE; e++) begin
                    acc_d[f][e] = '0;
                end
            end
            cnt_d   = CNT_LAST;
            turn_d  = 1'b0;
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (i_valid) begin
                        if (beat_ok) begin
                            for (int e = 0; e < NE; e++) begin
                                acc_d[i_addr][e] = acc_q[i_addr][e] + (partial[e] << i_bit);
                            end
                        end
                        if (i_last) begin
                            state_d = SEND;
                            turn_d  = 1'b1;
                        end
                    end
                end
                SEND: begin
                    // One turnaround cycle separates the last accepted beat from the first write.
                    if (turn_q) begin
                        turn_d = 1'b0;
                    end else if (i_ready) begin
                        we_d   = 1'b1;
                        data_d = quant_row;
                        if (cnt_q == '0) begin
                            done_d  = 1'b1;
                            cnt_d   = CNT_LAST;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_LAST;
            turn_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            for (int f = 0; f < FL; f++) begin
                for (int e = 0; e < NE; e++) begin
                    acc_q[f][e] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            turn_q  <= turn_d;
            we_q    <= we_d;
            done_q  <= done_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
        end
    end

    assign o_we   = we_q;
    assign o_done = done_q;
    assign o_data = data_q;
    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fc_obuf.sv
// tb/tb_fc_obuf.sv - self-checking bench for fc_obuf (OUT_SHIFT 0 and 7 instances, FC_OBUF_RELU_EN aware)
module tb_fc_obuf;

    localparam int ODS = 23;
    localparam int NE  = 2;
    localparam int FL  = 8;

`ifdef FC_OBUF_RELU_EN
    localparam int T5_E1_S0 = 0;
    localparam int T5_E1_S7 = 0;
    localparam int T5_BIG   = 255;
    localparam int T6_S0    = 255;
`else
    localparam int T5_E1_S0 = 255;
    localparam int T5_E1_S7 = 255;
    localparam int T5_BIG   = 160;
    localparam int T6_S0    = 44;
`endif

    logic        clk, rst, i_start, i_valid, i_last, i_ready;
    logic [2:0]  i_addr, i_bit;
    logic [45:0] i_data;
    logic        o_we0, o_busy0, o_done0, o_we7, o_busy7, o_done7;
    logic [15:0] o_data0, o_data7;

    fc_obuf #(.OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_addr(i_addr),
        .i_bit(i_bit), .i_last(i_last), .i_data(i_data), .i_ready(i_ready),
        .o_we(o_we0), .o_data(o_data0), .o_busy(o_busy0), .o_done(o_done0)
    );

    fc_obuf #(.OUT_SHIFT(7)) dut7 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_addr(i_addr),
        .i_bit(i_bit), .i_last(i_last), .i_data(i_data), .i_ready(i_ready),
        .o_we(o_we7), .o_data(o_data7), .o_busy(o_busy7), .o_done(o_done7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pass is a set of per-row sums; sending replays rows 7..0 once each.
    int          macc [FL][NE];
    int          rows [$];
    int          mode;
    bit          turn;
    bit          live = 1'b0;
    logic        exp_we, exp_done, exp_busy;
    logic [15:0] exp_data0, exp_data7;

    function automatic int quant(input int v, input int sh);
        int s;
        if (v >= 'h400000) v -= 'h800000;
        s = v >>> sh;
`ifdef FC_OBUF_RELU_EN
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
`else
        return s & 255;
`endif
    endfunction

    always @(posedge clk) begin
        int r, p;
        if (rst) begin
            live = 1'b1;
            mode = 0;
            turn = 1'b0;
            rows.delete();
            foreach (macc[f, e]) macc[f][e] = 0;
            exp_we    = 1'b0;
            exp_done  = 1'b0;
            exp_data0 = '0;
            exp_data7 = '0;
        end else begin
            exp_we   = 1'b0;
            exp_done = 1'b0;
            if (i_start) begin
                foreach (macc[f, e]) macc[f][e] = 0;
                rows.delete();
                turn = 1'b0;
                mode = 1;
            end else if (mode == 1) begin
                if (i_valid) begin
                    if (i_bit < 8 && i_addr < FL) begin
                        for (int e = 0; e < NE; e++) begin
                            p = int'($signed(i_data[e*ODS +: ODS]));
                            macc[i_addr][e] = (macc[i_addr][e] + (p <<< i_bit)) & 'h7FFFFF;
                        end
                    end
                    if (i_last) begin
                        mode = 2;
                        turn = 1'b1;
                        rows = '{7, 6, 5, 4, 3, 2, 1, 0};
                    end
                end
            end else if (mode == 2) begin
                if (turn) begin
                    turn = 1'b0;
                end else if (i_ready) begin
                    r = rows.pop_front();
                    exp_we = 1'b1;
                    for (int e = 0; e < NE; e++) begin
                        exp_data0[e*8 +: 8] = 8'(quant(macc[r][e], 0));
                        exp_data7[e*8 +: 8] = 8'(quant(macc[r][e], 7));
                    end
                    if (rows.size() == 0) begin
                        exp_done = 1'b1;
                        mode = 0;
                    end
                end
            end
        end
        exp_busy = (mode != 0);
    end

    always @(negedge clk) begin
        if (live) begin
            chk("dut0 o_we", 32'(o_we0), 32'(exp_we));
            chk("dut0 o_done", 32'(o_done0), 32'(exp_done));
            chk("dut0 o_busy", 32'(o_busy0), 32'(exp_busy));
            chk("dut0 o_data", 32'(o_data0), 32'(exp_data0));
            chk("dut7 o_we", 32'(o_we7), 32'(exp_we));
            chk("dut7 o_done", 32'(o_done7), 32'(exp_done));
            chk("dut7 o_busy", 32'(o_busy7), 32'(exp_busy));
            chk("dut7 o_data", 32'(o_data7), 32'(exp_data7));
        end
    end

    int b0 [$], b1 [$], b7 [$], b7h [$], bd [$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && o_we0) begin
            b0.push_back(int'(o_data0[7:0]));
            b1.push_back(int'(o_data0[15:8]));
            b7.push_back(int'(o_data7[7:0]));
            b7h.push_back(int'(o_data7[15:8]));
            bd.push_back(int'(o_done0));
        end
        if (!rst && o_done0) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        b0.delete(); b1.delete(); b7.delete(); b7h.delete(); bd.delete();
        done_cnt = 0;
    endtask

    task automatic start_pass();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic beat(input int a, input int b, input int d0, input int d1, input bit l);
        i_valid = 1'b1;
        i_addr  = 3'(a);
        i_bit   = 3'(b);
        i_data  = {23'(d1), 23'(d0)};
        i_last  = l;
        cyc();
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
    endtask

    task automatic do_send(input string name, input int pat);
        int  d0c;
        bit  got;
        d0c = done_cnt;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            i_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
            @(posedge clk);
            @(negedge clk);
            #1;
            if (done_cnt != d0c) got = 1'b1;
        end
        i_ready = 1'b0;
        chk({name, " send completes"}, 32'(got), 32'd1);
    endtask

    task automatic check_elem0(input string name, input int e0 [8]);
        chk({name, " beat count"}, 32'(b0.size()), 32'd8);
        chk({name, " done count"}, 32'(done_cnt), 32'd1);
        if (b0.size() == 8) begin
            for (int i = 0; i < 8; i++) chk({name, " elem0"}, 32'(b0[i]), 32'(e0[i]));
            chk({name, " done on last"}, 32'(bd[7]), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
        i_addr = '0; i_bit = '0; i_data = '0;
        cyc(); cyc();
        chk("reset o_we", 32'(o_we0), 32'd0);
        chk("reset o_data", 32'(o_data0), 32'd0);
        rst = 1'b0;
        cyc();

        // reset mid-ACCUM, then an empty pass
        start_pass();
        beat(1, 0, 77, 5, 1'b0);
        rst = 1'b1; cyc(); cyc(); rst = 1'b0; cyc();
        chk("t1 o_we", 32'(o_we0), 32'd0);
        chk("t1 o_busy", 32'(o_busy0), 32'd0);
        chk("t1 o_done", 32'(o_done0), 32'd0);
        clr();
        start_pass();
        beat(0, 0, 0, 0, 1'b1);
        do_send("t1", 0);
        check_elem0("t1", '{0, 0, 0, 0, 0, 0, 0, 0});

        // shift-add into row 0; beat coincident with i_start is dropped
        clr();
        i_valid = 1'b1; i_addr = 3'd0; i_bit = 3'd0; i_data = {23'd0, 23'd5};
        start_pass();
        i_valid = 1'b0; i_data = '0;
        beat(0, 0, 3, 0, 1'b0);
        beat(0, 2, 5, 0, 1'b0);
        beat(0, 0, 0, 0, 1'b1);
        do_send("t2", 0);
        check_elem0("t2", '{0, 0, 0, 0, 0, 0, 0, 23});
        if (b7.size() == 8) chk("t2 shift7 elem0", 32'(b7[7]), 32'd0);

        // row ordering, full ready
        clr();
        start_pass();
        for (int r = 0; r < 8; r++) beat(r, 0, r + 1, 0, r == 7);
        do_send("t3", 0);
        check_elem0("t3", '{8, 7, 6, 5, 4, 3, 2, 1});

        // same pass under i_ready stalls
        clr();
        start_pass();
        for (int r = 0; r < 8; r++) beat(r, 0, r + 1, 0, r == 7);
        do_send("t4", 1);
        check_elem0("t4", '{8, 7, 6, 5, 4, 3, 2, 1});

        // negative partial and a large value that the shift brings back into range
        clr();
        start_pass();
        beat(0, 0, 0, -1, 1'b0);
        beat(1, 2, 1000, 0, 1'b1);
        do_send("t5", 0);
        chk("t5 beat count", 32'(b1.size()), 32'd8);
        if (b1.size() == 8) begin
            chk("t5 elem1 shift0", 32'(b1[7]), 32'(T5_E1_S0));
            chk("t5 elem1 shift7", 32'(b7h[7]), 32'(T5_E1_S7));
            chk("t5 big shift0", 32'(b0[6]), 32'(T5_BIG));
            chk("t5 big shift7", 32'(b7[6]), 32'd31);
        end

        // 300 overflows the activation width
        clr();
        start_pass();
        beat(2, 0, 300, 0, 1'b1);
        do_send("t6", 0);
        chk("t6 beat count", 32'(b0.size()), 32'd8);
        if (b0.size() == 8) begin
            chk("t6 shift0", 32'(b0[5]), 32'(T6_S0));
            chk("t6 shift7", 32'(b7[5]), 32'd2);
        end

        // i_start aborts SEND
        clr();
        start_pass();
        beat(3, 0, 9, 4, 1'b1);
        i_ready = 1'b1;
        repeat (4) cyc();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        i_ready = 1'b0;
        chk("t7 busy after abort", 32'(o_busy0), 32'd1);
        cyc();
        chk("t7 no done", 32'(done_cnt), 32'd0);
        clr();
        beat(0, 0, 0, 0, 1'b1);
        do_send("t7", 0);
        check_elem0("t7", '{0, 0, 0, 0, 0, 0, 0, 0});
        chk("t7 elem1 cleared", 32'(b1.size() == 8 ? b1[4] : -1), 32'd0);

        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
